// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Increment modulo n, for the round-robin pointer.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_fifo.sv
// Plain synchronous fifo storage. Fall-through read of the head entry.
// Occupancy tracking and full/empty guarding are left to the instantiating block.
module fifo_wr_arbiter_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  // Pointer advance; natural wrap modulo depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one fifo write port among NUM_REQ
// producers. Grant is registered: one IDLE cycle separates consecutive grants.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic                          grant_vld,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [ADDR_WIDTH:0]           level
);

  localparam int GW    = $clog2(NUM_REQ);
  localparam int BW    = $clog2(MAX_BURST + 1);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t                state, state_nxt;
  logic [GW-1:0]         rr_ptr;
  logic [GW-1:0]         pick;
  logic                  any_req;
  logic [BW-1:0]         beat_cnt;
  logic                  full, push, pop, rel;
  logic [DATA_WIDTH-1:0] wdata;

  assign full      = (level == (ADDR_WIDTH + 1)'(DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  assign grant_vld = (state == ST_GRANT);
  assign wdata     = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign push      = grant_vld & req_valid[grant_id] & ~full;
  // Owner leaves on a completed burst or as soon as it stops presenting data;
  // a full fifo with valid held keeps the grant.
  assign rel       = grant_vld & (~req_valid[grant_id] |
                                  (push & (beat_cnt == BW'(MAX_BURST - 1))));

  // Rotate-and-priority-encode: scan from the highest offset down so the
  // requester closest to rr_ptr wins.
  always_comb begin
    int idx;
    idx     = 0;
    pick    = rr_ptr;
    any_req = |req_valid;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) pick = GW'(idx);
    end
  end

  // Only the owner sees ready, and only while there is room.
  always_comb begin
    req_ready = '0;
    if (grant_vld && !full) req_ready[grant_id] = 1'b1;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_GRANT;
      ST_GRANT: if (rel)     state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Grant owner, burst counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        grant_id <= pick;
        beat_cnt <= '0;
      end else if (push) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (rel) rr_ptr <= GW'(wrap_inc(32'(grant_id), NUM_REQ));
    end
  end

  // Occupancy mirrors the fifo's push/pop traffic.
  always_ff @(posedge clk) begin
    if (rst) level <= '0;
    else begin
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  fifo_wr_arbiter_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (push),
    .wr_data(wdata),
    .rd_en  (pop),
    .rd_data(out_data)
  );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int N = 4, DW = 8, AW = 4, MB = 4, DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic            grant_vld;
  logic [1:0]      grant_id;
  logic [AW:0]     level;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .grant_vld(grant_vld), .grant_id(grant_id), .level(level)
  );

  int errors = 0, checks = 0;

  // Producer stimulus: each producer emits base+k for its k-th accepted beat
  // while enabled and below its beat limit.
  bit        en   [N];
  int        lim  [N];
  int        sent [N];
  logic [7:0] base[N];

  // Model: current owner (if any), beats taken in this grant, next scan start,
  // and the fifo contents as a queue.
  bit        m_gv;
  int        m_gid, m_rr, m_cnt;
  logic [7:0] q[$];
  logic [7:0] popped[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = en[i] && (sent[i] < lim[i]);
      req_data[i*DW +: DW]   = base[i] + 8'(sent[i]);
    end
  endtask

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    r = '0;
    if (m_gv && q.size() < DEPTH) r[m_gid] = 1'b1;
    return r;
  endfunction

  task automatic compare();
    check("req_ready", int'(req_ready), int'(m_ready()));
    check("grant_vld", int'(grant_vld), int'(m_gv));
    if (m_gv) check("grant_id", int'(grant_id), m_gid);
    check("level", int'(level), q.size());
    check("out_valid", int'(out_valid), int'(q.size() != 0));
    if (q.size() != 0) check("out_data", int'(out_data), int'(q[0]));
    if (q.size() != 0 && out_ready) popped.push_back(q[0]);
  endtask

  task automatic step();
    logic [N-1:0] rv, rdy;
    logic [7:0]   d;
    bit           push, pop;
    rv   = req_valid;
    rdy  = m_ready();
    push = m_gv && rv[m_gid] && rdy[m_gid];
    pop  = (q.size() != 0) && out_ready;
    d    = base[m_gid] + 8'(sent[m_gid]);
    for (int i = 0; i < N; i++) if (rv[i] && rdy[i]) sent[i]++;
    if (rst) begin
      q.delete();
      m_gv = 0; m_gid = 0; m_rr = 0; m_cnt = 0;
      return;
    end
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(d);
    if (m_gv) begin
      if (push) m_cnt++;
      if ((push && m_cnt == MB) || !rv[m_gid]) begin
        m_gv = 0;
        m_rr = (m_gid + 1) % N;
      end
    end else if (rv != '0) begin
      for (int k = N - 1; k >= 0; k--)
        if (rv[(m_rr + k) % N]) m_gid = (m_rr + k) % N;
      m_gv  = 1;
      m_cnt = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    step();
    #1;
    drive();
  endtask

  task automatic all_off();
    for (int i = 0; i < N; i++) en[i] = 0;
    drive();
  endtask

  task automatic do_reset();
    all_off();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive();
  endtask

  initial begin
    int pat;
    int gids[$];
    bit prev;
    bool_wait: begin end
    rst = 1'b1;
    out_ready = 1'b0;
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      en[i] = 0; lim[i] = 0; sent[i] = 0;
    end
    base[0] = 8'h10; base[1] = 8'h40; base[2] = 8'h80; base[3] = 8'hC0;
    m_gv = 0; m_gid = 0; m_rr = 0; m_cnt = 0;
    drive();
    cycle();
    cycle();
    rst = 1'b0;
    check("reset_level", int'(level), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_grant_vld", int'(grant_vld), 0);
    check("reset_grant_id", int'(grant_id), 0);
    check("reset_req_ready", int'(req_ready), 0);

    // Single producer, 6 beats: 4-beat burst, one IDLE cycle, 2 more beats.
    popped.delete();
    en[0] = 1; lim[0] = 6; out_ready = 1'b1;
    drive();
    pat = 0;
    for (int c = 0; c < 10; c++) begin
      pat |= int'(grant_vld) << c;
      cycle();
    end
    check("t1_grant_pattern", pat, 'h1DE);
    cycle(); cycle();
    check("t1_popped_count", popped.size(), 6);
    for (int k = 0; k < 6 && k < popped.size(); k++)
      check("t1_popped_data", int'(popped[k]), 'h10 + k);

    // All producers valid: grant order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) begin en[i] = 1; lim[i] = sent[i] + 100; end
    drive();
    prev = 0;
    for (int c = 0; c < 40 && gids.size() < 5; c++) begin
      if (grant_vld && !prev) gids.push_back(int'(grant_id));
      prev = grant_vld;
      cycle();
    end
    check("t2_grant_count", gids.size(), 5);
    for (int k = 0; k < 5 && k < gids.size(); k++)
      check("t2_grant_order", gids[k], (k == 4) ? 0 : k);
    all_off();
    repeat (20) cycle();

    // Fill to full with producer 2, then a single pop.
    do_reset();
    en[2] = 1; lim[2] = sent[2] + 20; out_ready = 1'b0;
    drive();
    repeat (24) cycle();
    check("t3_level_full", int'(level), 16);
    check("t3_ready_full", int'(req_ready), 0);
    check("t3_grant_held", int'(grant_vld), 1);
    check("t3_grant_id", int'(grant_id), 2);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("t3_level_after_pop", int'(level), 15);
    check("t3_ready_after_pop", int'(req_ready), 'b0100);
    cycle();
    check("t3_level_refill", int'(level), 16);
    all_off();
    out_ready = 1'b1;
    repeat (20) cycle();

    // Early release by producer 1 moves the pointer to 2; 3 wins over 0.
    do_reset();
    en[1] = 1; lim[1] = sent[1] + 2;
    drive();
    repeat (5) cycle();
    en[0] = 1; lim[0] = sent[0] + 100;
    en[3] = 1; lim[3] = sent[3] + 100;
    drive();
    cycle();
    check("t4_grant_vld", int'(grant_vld), 1);
    check("t4_grant_id", int'(grant_id), 3);
    all_off();
    repeat (20) cycle();

    // Full fifo with continuous drain: pops and pushes across the wrap.
    do_reset();
    en[3] = 1; lim[3] = sent[3] + 70; out_ready = 1'b0;
    drive();
    repeat (24) cycle();
    out_ready = 1'b1;
    cycle();
    check("t5_first_pop_level", int'(level), 15);
    repeat (40) cycle();
    all_off();
    repeat (20) cycle();

    // Reset mid-burst at level 7.
    do_reset();
    en[0] = 1; lim[0] = sent[0] + 20; out_ready = 1'b0;
    drive();
    for (int c = 0; c < 40 && q.size() != 7; c++) cycle();
    check("t6_level_before_reset", int'(level), 7);
    check("t6_mid_burst", int'(grant_vld), 1);
    rst = 1'b1;
    en[0] = 0; en[2] = 1; en[3] = 1;
    lim[2] = sent[2] + 100; lim[3] = sent[3] + 100;
    drive();
    cycle();
    rst = 1'b0;
    drive();
    check("t6_level", int'(level), 0);
    check("t6_out_valid", int'(out_valid), 0);
    check("t6_grant_vld", int'(grant_vld), 0);
    check("t6_req_ready", int'(req_ready), 0);
    cycle();
    check("t6_first_grant", int'(grant_id), 2);
    check("t6_first_grant_vld", int'(grant_vld), 1);
    all_off();

    // Random traffic.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (c % 8 == 0)
        for (int i = 0; i < N; i++) begin
          en[i]   = ($urandom_range(0, 2) != 0);
          lim[i]  = sent[i] + int'($urandom_range(0, 10));
          if (c % 64 == 0) base[i] = 8'($urandom);
        end
      out_ready = ($urandom_range(0, 3) != 0);
      drive();
      cycle();
    end
    all_off();
    out_ready = 1'b1;
    repeat (25) cycle();
    check("final_drained", int'(level), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
